// File: rtl/audio_stream_ctrl.sv
// Buffered line-in -> line-out sequencer for audio_codec: pulls ADC pairs into a FIFO,
// prefills, then plays them out to the DAC with volume shift and mute.
module audio_stream_ctrl #(
  parameter int DATA_W  = 24,
  parameter int DEPTH   = 16,
  parameter int PREFILL = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mute,
  input  logic [2:0]               volume,
  input  logic                     read_ready,
  input  logic [DATA_W-1:0]        readdata_left,
  input  logic [DATA_W-1:0]        readdata_right,
  input  logic                     write_ready,
  output logic                     read,
  output logic                     write,
  output logic [DATA_W-1:0]        writedata_left,
  output logic [DATA_W-1:0]        writedata_right,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     running,
  output logic [15:0]              overflow_count,
  output logic [15:0]              underflow_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LEVEL    = (PW+1)'(DEPTH);
  localparam logic [PW:0] PREFILL_LEVEL = (PW+1)'(PREFILL);

  typedef enum logic {FILL, RUN} state_t;

  state_t                state;
  logic [2*DATA_W-1:0]   mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  logic                  wr_slot;
  logic                  pop;
  logic                  push_ok;
  logic [2*DATA_W-1:0]   head;
  logic signed [DATA_W-1:0] head_left;
  logic signed [DATA_W-1:0] head_right;
  logic [DATA_W-1:0]     scaled_left;
  logic [DATA_W-1:0]     scaled_right;

  // A pop frees a slot in the same cycle, so a full FIFO still takes the incoming pair.
  always_comb begin
    wr_slot      = enable && write_ready && !write;
    pop          = wr_slot && (state == RUN) && (fill_level != '0);
    push_ok      = read && ((fill_level != FULL_LEVEL) || pop);
    head         = mem[rd_ptr];
    head_left    = head[2*DATA_W-1:DATA_W];
    head_right   = head[DATA_W-1:0];
    scaled_left  = mute ? '0 : DATA_W'(head_left >>> volume);
    scaled_right = mute ? '0 : DATA_W'(head_right >>> volume);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset && enable && push_ok)
      mem[wr_ptr] <= {readdata_left, readdata_right};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state           <= FILL;
      running         <= 1'b0;
      read            <= 1'b0;
      write           <= 1'b0;
      writedata_left  <= '0;
      writedata_right <= '0;
      fill_level      <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      overflow_count  <= '0;
      underflow_count <= '0;
    end else if (!enable) begin
      state      <= FILL;
      running    <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      fill_level <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      read  <= read_ready && !read;
      write <= wr_slot;

      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      else if (read && (overflow_count != 16'hFFFF))
        overflow_count <= overflow_count + 16'd1;

      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      case ({push_ok, pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase

      case (state)
        FILL: begin
          if (wr_slot) begin
            writedata_left  <= '0;
            writedata_right <= '0;
          end
          if (fill_level >= PREFILL_LEVEL) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (wr_slot) begin
            // Running dry: emit silence and go back to prefilling.
            if (fill_level == '0) begin
              state           <= FILL;
              running         <= 1'b0;
              writedata_left  <= '0;
              writedata_right <= '0;
              if (underflow_count != 16'hFFFF)
                underflow_count <= underflow_count + 16'd1;
            end else begin
              writedata_left  <= scaled_left;
              writedata_right <= scaled_right;
            end
          end
        end
        default: begin
          state   <= FILL;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
